// File: rtl/ex_md_stage_pkg.sv
// ex_md_stage_pkg: shared encodings for the execute stage.
// Holds the ALU opcodes, the mdOpE encodings, the forward-select encodings,
// and small decode helpers for the multiply/divide opcodes.
package ex_md_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    // Opcodes that start the multiply/divide engine.
    function automatic logic md_arith(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

    // Opcodes that touch HI/LO and therefore must wait for a busy engine.
    function automatic logic md_any(input logic [3:0] op);
        return op inside {[4'd1:4'd8]};
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational ALU; shifts move b_i by the low bits of a_i.
// Ports: a_i, b_i operands; op_i opcode; y_o result.
module alu
    import ex_md_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [ALU_OP_W-1:0] op_i,
    output logic [DATA_W-1:0]   y_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;

    assign sh = a_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_OP_W'(ALU_ADD):  y_o = a_i + b_i;
            ALU_OP_W'(ALU_SUB):  y_o = a_i - b_i;
            ALU_OP_W'(ALU_AND):  y_o = a_i & b_i;
            ALU_OP_W'(ALU_OR):   y_o = a_i | b_i;
            ALU_OP_W'(ALU_XOR):  y_o = a_i ^ b_i;
            ALU_OP_W'(ALU_NOR):  y_o = ~(a_i | b_i);
            ALU_OP_W'(ALU_SLT):  y_o = DATA_W'($signed(a_i) < $signed(b_i));
            ALU_OP_W'(ALU_SLTU): y_o = DATA_W'(a_i < b_i);
            ALU_OP_W'(ALU_SLL):  y_o = b_i << sh;
            ALU_OP_W'(ALU_SRL):  y_o = b_i >> sh;
            ALU_OP_W'(ALU_SRA):  y_o = $signed(b_i) >>> sh;
            ALU_OP_W'(ALU_LUI):  y_o = b_i << 16;
            default:             y_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply / restoring divide engine owning HI and LO.
// Ports: start issues op (MULT/MULTU/DIV/DIVU) on operands a, b; mt_hi/mt_lo
// load mt_data into HI/LO; busy is high while an operation is in flight;
// hi/lo are the architectural registers.
module muldiv_unit
    import ex_md_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mt_hi,
    input  logic              mt_lo,
    input  logic [DATA_W-1:0] mt_data,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_MAX = DATA_W > MUL_LAT ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   a_q, b_q, q_q, r_q, d_q, hi_q, lo_q;
    logic                sgn_q, neg_q_q, neg_r_q, dz_q;
    logic                op_mul, op_signed, a_neg, b_neg, ge;
    logic [DATA_W-1:0]   a_mag, b_mag, q_d, r_d;
    logic [DATA_W:0]     rr;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod_d;

    assign op_mul    = op == MD_MULT || op == MD_MULTU;
    assign op_signed = op == MD_MULT || op == MD_DIV;
    assign a_neg     = op_signed & a[DATA_W-1];
    assign b_neg     = op_signed & b[DATA_W-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // The low 2W bits of the product of sign-extended operands equal the signed product.
    assign a_ext  = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    assign b_ext  = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod_d = a_ext * b_ext;

    // One restoring step: the remainder is always below the divisor, so W-bit wraparound is exact.
    assign rr  = {r_q, q_q[DATA_W-1]};
    assign ge  = rr >= {1'b0, d_q};
    assign r_d = ge ? rr[DATA_W-1:0] - d_q : rr[DATA_W-1:0];
    assign q_d = {q_q[DATA_W-2:0], ge};

    assign busy = state_q != S_IDLE;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= op_mul ? S_MUL : S_DIV;
                        cnt_q   <= op_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(DATA_W);
                        a_q     <= a;
                        b_q     <= b;
                        sgn_q   <= op_signed;
                        q_q     <= a_mag;
                        r_q     <= '0;
                        d_q     <= b_mag;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        dz_q    <= b == '0;
                    end else begin
                        if (mt_hi) hi_q <= mt_data;
                        if (mt_lo) lo_q <= mt_data;
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= prod_d;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    // Final step applies the signs; divide-by-zero overrides with its fixed result.
                    if (cnt_q == '0) begin
                        hi_q    <= dz_q ? a_q : neg_r_q ? -r_q : r_q;
                        lo_q    <= dz_q ? '1 : neg_q_q ? -q_q : q_q;
                        state_q <= S_IDLE;
                    end else begin
                        q_q   <= q_d;
                        r_q   <= r_d;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_md_stage.sv
// ex_md_stage: execute stage with forwarding, operand select, ALU and mul/div unit.
// Ports: forwardAE/BE pick regfile/aluOutM/wbOut operands; aluSrc1/2 select
// shift amount / immediate; mdOpE drives the HI/LO unit; outputs are the
// destination register, ALU (or HI/LO) result, store data, stall and busy.
module ex_md_stage
    import ex_md_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 4,
    parameter int MUL_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flushE,
    input  logic [1:0]          forwardAE,
    input  logic [1:0]          forwardBE,
    input  logic [REG_AW-1:0]   rsE,
    input  logic [REG_AW-1:0]   rtE,
    input  logic [REG_AW-1:0]   rdE,
    input  logic [ALU_OP_W-1:0] aluOpE,
    input  logic                aluSrc1_muxE,
    input  logic                aluSrc2_muxE,
    input  logic                extOpE,
    input  logic                regDst_muxE,
    input  logic [3:0]          mdOpE,
    input  logic [DATA_W-1:0]   readData1E,
    input  logic [DATA_W-1:0]   readData2E,
    input  logic [DATA_W-1:0]   aluOutM,
    input  logic [DATA_W-1:0]   wbOut,
    input  logic [4:0]          saE,
    input  logic [15:0]         imm16E,
    output logic [REG_AW-1:0]   writeRegAddrE,
    output logic [DATA_W-1:0]   aluOutE,
    output logic [DATA_W-1:0]   writeDataE,
    output logic                stallE,
    output logic                mdBusy
);
    logic [DATA_W-1:0] fwd_a, fwd_b, src_a, src_b, imm_ext, alu_y, hi, lo;
    logic              md_go, unused_rs;

    // rs is consumed by the hazard unit, not here.
    assign unused_rs = ^rsE;

    assign fwd_a = forwardAE == FWD_MEM ? aluOutM : forwardAE == FWD_WB ? wbOut : readData1E;
    assign fwd_b = forwardBE == FWD_MEM ? aluOutM : forwardBE == FWD_WB ? wbOut : readData2E;

    assign imm_ext = extOpE ? DATA_W'($signed(imm16E)) : DATA_W'(imm16E);
    assign src_a   = aluSrc1_muxE ? DATA_W'(saE) : fwd_a;
    assign src_b   = aluSrc2_muxE ? imm_ext : fwd_b;

    assign writeRegAddrE = regDst_muxE ? rdE : rtE;
    assign writeDataE    = fwd_b;

    // Only HI/LO users wait on the engine; a flushed op may still stall, flush wins upstream.
    assign stallE  = mdBusy & md_any(mdOpE);
    assign md_go   = ~stallE & ~flushE;
    assign aluOutE = mdOpE == MD_MFHI ? hi : mdOpE == MD_MFLO ? lo : alu_y;

    alu #(
        .DATA_W  (DATA_W),
        .ALU_OP_W(ALU_OP_W)
    ) u_alu (
        .a_i (src_a),
        .b_i (src_b),
        .op_i(aluOpE),
        .y_o (alu_y)
    );

    muldiv_unit #(
        .DATA_W (DATA_W),
        .MUL_LAT(MUL_LAT)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_go & md_arith(mdOpE)),
        .op     (mdOpE),
        .a      (fwd_a),
        .b      (fwd_b),
        .mt_hi  (md_go & (mdOpE == MD_MTHI)),
        .mt_lo  (md_go & (mdOpE == MD_MTLO)),
        .mt_data(fwd_a),
        .busy   (mdBusy),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_ex_md_stage.sv
// tb_ex_md_stage: table-driven datapath vectors plus scoreboarded HI/LO sequences.
module tb_ex_md_stage;
    import ex_md_stage_pkg::*;

    localparam int W = 32;

    logic         clk, rst, flushE;
    logic [1:0]   forwardAE, forwardBE;
    logic [4:0]   rsE, rtE, rdE, saE;
    logic [3:0]   aluOpE, mdOpE;
    logic         aluSrc1_muxE, aluSrc2_muxE, extOpE, regDst_muxE;
    logic [W-1:0] readData1E, readData2E, aluOutM, wbOut;
    logic [15:0]  imm16E;
    logic [4:0]   writeRegAddrE;
    logic [W-1:0] aluOutE, writeDataE;
    logic         stallE, mdBusy;

    ex_md_stage #(.DATA_W(W), .REG_AW(5), .ALU_OP_W(4), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .aluOpE(aluOpE),
        .aluSrc1_muxE(aluSrc1_muxE), .aluSrc2_muxE(aluSrc2_muxE),
        .extOpE(extOpE), .regDst_muxE(regDst_muxE), .mdOpE(mdOpE),
        .readData1E(readData1E), .readData2E(readData2E),
        .aluOutM(aluOutM), .wbOut(wbOut), .saE(saE), .imm16E(imm16E),
        .writeRegAddrE(writeRegAddrE), .aluOutE(aluOutE), .writeDataE(writeDataE),
        .stallE(stallE), .mdBusy(mdBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]   fa, fb;
        logic [3:0]   op;
        logic         s1, s2, ext, rdst;
        logic [W-1:0] rd1, rd2;
        logic [4:0]   sa;
        logic [15:0]  imm;
        logic [W-1:0] ealu;
        logic [4:0]   ewr;
        logic [W-1:0] ewd;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi, lo;
        int           lat;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] fa, fb, input logic [3:0] op,
                                input logic s1, s2, ext, rdst,
                                input logic [W-1:0] rd1, rd2, input logic [4:0] sa,
                                input logic [15:0] imm, input logic [W-1:0] ealu,
                                input logic [4:0] ewr, input logic [W-1:0] ewd);
        vec_t v;
        v.fa = fa; v.fb = fb; v.op = op; v.s1 = s1; v.s2 = s2; v.ext = ext; v.rdst = rdst;
        v.rd1 = rd1; v.rd2 = rd2; v.sa = sa; v.imm = imm;
        v.ealu = ealu; v.ewr = ewr; v.ewd = ewd;
        return v;
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [W-1:0] a, b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] r = '0;
        case (op)
            MD_MULT:  r = 64'(sa * sb);
            MD_MULTU: r = ua * ub;
            MD_DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            MD_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default:  r = '0;
        endcase
        return r;
    endfunction

    task automatic md_issue(input logic [3:0] op, input logic [W-1:0] a, b,
                            input logic [W-1:0] ehi, elo);
        exp_t e;
        mdOpE = op; readData1E = a; readData2E = b;
        forwardAE = 2'b00; forwardBE = 2'b00; flushE = 1'b0;
        #1;
        chk("issue_no_stall", stallE, 0);
        e.hi = ehi; e.lo = elo; e.lat = (op == MD_MULT || op == MD_MULTU) ? 2 : 33;
        sb.push_back(e);
        step();
        mdOpE = MD_MFHI;
    endtask

    task automatic md_drain();
        int n = 0;
        exp_t e;
        #1;
        chk("busy_after_issue", mdBusy, 1);
        while (stallE === 1'b1 && n < 200) begin
            step();
            n++;
        end
        e = sb.pop_front();
        chk("stall_cycles", 32'(n), 32'(e.lat));
        chk("mfhi", aluOutE, e.hi);
        mdOpE = MD_MFLO;
        #1;
        chk("mflo", aluOutE, e.lo);
        mdOpE = MD_NONE;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flushE = 1'b0; forwardAE = 2'b00; forwardBE = 2'b00;
        rsE = 5'd1; rtE = 5'd3; rdE = 5'd9; saE = '0; imm16E = '0;
        aluOpE = ALU_ADD; mdOpE = MD_NONE;
        aluSrc1_muxE = 1'b0; aluSrc2_muxE = 1'b0; extOpE = 1'b0; regDst_muxE = 1'b0;
        readData1E = '0; readData2E = '0; aluOutM = 32'h10; wbOut = 32'h20;

        tv.push_back(mk(2'b01, 2'b00, ALU_ADD, 0, 0, 0, 0, 32'h1, 32'h5, 0, 16'h0, 32'h15, 3, 32'h5));
        tv.push_back(mk(2'b10, 2'b00, ALU_ADD, 0, 0, 0, 0, 32'h1, 32'h5, 0, 16'h0, 32'h25, 3, 32'h5));
        tv.push_back(mk(2'b11, 2'b00, ALU_ADD, 0, 0, 0, 0, 32'h1, 32'h5, 0, 16'h0, 32'h6, 3, 32'h5));
        tv.push_back(mk(2'b00, 2'b01, ALU_ADD, 0, 0, 0, 0, 32'h1, 32'h5, 0, 16'h0, 32'h11, 3, 32'h10));
        tv.push_back(mk(2'b00, 2'b10, ALU_SUB, 0, 0, 0, 1, 32'h30, 32'h5, 0, 16'h0, 32'h10, 9, 32'h20));
        tv.push_back(mk(2'b00, 2'b00, ALU_SUB, 0, 1, 1, 1, 32'h1, 32'h5, 0, 16'hFFFF, 32'h2, 9, 32'h5));
        tv.push_back(mk(2'b00, 2'b00, ALU_OR, 0, 1, 0, 0, 32'h10000, 32'h5, 0, 16'hFFFF, 32'h1FFFF, 3, 32'h5));
        tv.push_back(mk(2'b00, 2'b00, ALU_OR, 0, 1, 1, 0, 32'h0, 32'h5, 0, 16'h8000, 32'hFFFF8000, 3, 32'h5));
        tv.push_back(mk(2'b00, 2'b00, ALU_SLL, 1, 0, 0, 0, 32'hFFFFFFFF, 32'h5, 4, 16'h0, 32'h50, 3, 32'h5));
        tv.push_back(mk(2'b00, 2'b00, ALU_SRA, 1, 0, 0, 0, 32'h0, 32'h80000000, 1, 16'h0, 32'hC0000000, 3, 32'h80000000));
        tv.push_back(mk(2'b00, 2'b00, ALU_SRL, 1, 0, 0, 0, 32'h0, 32'h80000000, 31, 16'h0, 32'h1, 3, 32'h80000000));
        tv.push_back(mk(2'b00, 2'b00, ALU_SLT, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 16'h0, 32'h1, 3, 32'h1));
        tv.push_back(mk(2'b00, 2'b00, ALU_SLTU, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 16'h0, 32'h0, 3, 32'h1));
        tv.push_back(mk(2'b00, 2'b00, ALU_AND, 0, 0, 0, 0, 32'hF0F0, 32'h0FF0, 0, 16'h0, 32'h00F0, 3, 32'h0FF0));
        tv.push_back(mk(2'b00, 2'b00, ALU_XOR, 0, 0, 0, 0, 32'hF0F0, 32'h0FF0, 0, 16'h0, 32'hFF00, 3, 32'h0FF0));
        tv.push_back(mk(2'b00, 2'b00, ALU_NOR, 0, 0, 0, 0, 32'h0, 32'h0, 0, 16'h0, 32'hFFFFFFFF, 3, 32'h0));
        tv.push_back(mk(2'b00, 2'b00, ALU_LUI, 0, 1, 0, 0, 32'h0, 32'h0, 0, 16'h1234, 32'h12340000, 3, 32'h0));

        repeat (2) step();
        chk("reset_busy", mdBusy, 0);
        mdOpE = MD_MFHI;
        #1;
        chk("reset_stall", stallE, 0);
        chk("reset_hi", aluOutE, 0);
        mdOpE = MD_MFLO;
        #1;
        chk("reset_lo", aluOutE, 0);
        mdOpE = MD_NONE;
        rst = 1'b0;
        step();

        foreach (tv[i]) begin
            forwardAE = tv[i].fa; forwardBE = tv[i].fb; aluOpE = tv[i].op;
            aluSrc1_muxE = tv[i].s1; aluSrc2_muxE = tv[i].s2; extOpE = tv[i].ext;
            regDst_muxE = tv[i].rdst; readData1E = tv[i].rd1; readData2E = tv[i].rd2;
            saE = tv[i].sa; imm16E = tv[i].imm;
            #1;
            chk($sformatf("vec%0d_alu", i), aluOutE, tv[i].ealu);
            chk($sformatf("vec%0d_wreg", i), 32'(writeRegAddrE), 32'(tv[i].ewr));
            chk($sformatf("vec%0d_wdata", i), writeDataE, tv[i].ewd);
            chk($sformatf("vec%0d_nostall", i), stallE, 0);
        end
        aluOpE = ALU_ADD; aluSrc1_muxE = 0; aluSrc2_muxE = 0; extOpE = 0; regDst_muxE = 0;
        step();

        md_issue(MD_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE); md_drain();
        md_issue(MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE); md_drain();
        md_issue(MD_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD); md_drain();
        md_issue(MD_DIVU, 32'h7, 32'h2, 32'h1, 32'h3); md_drain();
        md_issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000); md_drain();
        md_issue(MD_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF); md_drain();

        mdOpE = MD_MTHI; readData1E = 32'h1234;
        step();
        mdOpE = MD_MFHI;
        #1;
        chk("mthi_mfhi", aluOutE, 32'h1234);
        mdOpE = MD_MTLO; readData1E = 32'hDEAD; flushE = 1'b1;
        step();
        flushE = 1'b0; mdOpE = MD_MFLO;
        #1;
        chk("mtlo_flushed", aluOutE, 32'hFFFFFFFF);
        mdOpE = MD_DIV; readData1E = 32'h9; readData2E = 32'h3; flushE = 1'b1;
        step();
        flushE = 1'b0; mdOpE = MD_NONE;
        #1;
        chk("div_flushed_busy", mdBusy, 0);

        begin
            int n = 0;
            exp_t e;
            mdOpE = MD_DIVU; readData1E = 32'h7; readData2E = 32'h2;
            step();
            mdOpE = MD_MULT; readData1E = 32'h3; readData2E = 32'h5;
            #1;
            while (stallE === 1'b1 && n < 200) begin
                step();
                n++;
            end
            chk("b2b_stall_cycles", 32'(n), 33);
            e.hi = 32'h0; e.lo = 32'hF; e.lat = 2;
            sb.push_back(e);
            step();
            mdOpE = MD_MFHI;
            md_drain();
        end

        mdOpE = MD_DIV; readData1E = 32'hFFFFFFF9; readData2E = 32'h2;
        step();
        mdOpE = MD_NONE;
        repeat (4) step();
        chk("nonmd_no_stall", stallE, 0);
        chk("div_midway_busy", mdBusy, 1);
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", mdBusy, 0);
        mdOpE = MD_MFHI;
        #1;
        chk("rst_mid_stall", stallE, 0);
        chk("rst_mid_hi", aluOutE, 0);
        mdOpE = MD_MFLO;
        #1;
        chk("rst_mid_lo", aluOutE, 0);
        mdOpE = MD_NONE;
        step();
        rst = 1'b0;
        step();
        md_issue(MD_MULT, 32'h3, 32'h4, 32'h0, 32'hC); md_drain();

        for (int i = 0; i < 8; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            logic [63:0]  m;
            op = 4'(1 + i % 4);
            a = $urandom;
            b = (i < 4) ? $urandom : 32'($urandom_range(0, 300)) - 32'd150;
            m = model(op, a, b);
            md_issue(op, a, b, m[63:32], m[31:0]);
            md_drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
